// File: rtl/execute.sv
// rtl/execute.sv - Y86-64 execute stage: ALU, condition evaluation and condition-code register
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  input  logic [2:0]  CondititonCodes_In,
  output logic [63:0] valE,
  output logic        Condition,
  output logic [2:0]  CondititonCodes_Out
);

  localparam logic [3:0] iRrmovq = 4'h2;
  localparam logic [3:0] iIrmovq = 4'h3;
  localparam logic [3:0] iRmmovq = 4'h4;
  localparam logic [3:0] iMrmovq = 4'h5;
  localparam logic [3:0] iOpq    = 4'h6;
  localparam logic [3:0] iJxx    = 4'h7;
  localparam logic [3:0] iCall   = 4'h8;
  localparam logic [3:0] iRet    = 4'h9;
  localparam logic [3:0] iPushq  = 4'hA;
  localparam logic [3:0] iPopq   = 4'hB;

  logic        zfIn, sfIn, ofIn;
  logic        opValid;
  logic [63:0] opResult;
  logic        opOverflow;
  logic [2:0]  newFlags;
  logic [2:0]  ccReg;

  assign zfIn = CondititonCodes_In[2];
  assign sfIn = CondititonCodes_In[1];
  assign ofIn = CondititonCodes_In[0];

  // OPq datapath; operands are only looked at for the ops that need them
  always_comb begin
    opResult   = 64'd0;
    opOverflow = 1'b0;
    opValid    = 1'b0;
    case (ifun)
      4'h0: begin
        opResult   = valB + valA;
        opOverflow = (valA[63] == valB[63]) && (opResult[63] != valB[63]);
        opValid    = 1'b1;
      end
      4'h1: begin
        opResult   = valB - valA;
        opOverflow = (valA[63] != valB[63]) && (opResult[63] != valB[63]);
        opValid    = 1'b1;
      end
      4'h2: begin
        opResult = valB & valA;
        opValid  = 1'b1;
      end
      4'h3: begin
        opResult = valB ^ valA;
        opValid  = 1'b1;
      end
      default: begin
        opResult   = 64'd0;
        opOverflow = 1'b0;
        opValid    = 1'b0;
      end
    endcase
  end

  assign newFlags = {(opResult == 64'd0), opResult[63], opOverflow};

  always_comb begin
    valE = 64'd0;
    case (icode)
      iRrmovq:          valE = valA;
      iIrmovq:          valE = valC;
      iRmmovq, iMrmovq: valE = valB + valC;
      iOpq:             valE = opResult;
      iCall, iPushq:    valE = valB - 64'd8;
      iRet, iPopq:      valE = valB + 64'd8;
      default:          valE = 64'd0;
    endcase
  end

  // Flags are consulted only for cmov/jump, so X flags elsewhere stay harmless
  always_comb begin
    Condition = 1'b0;
    if (icode == iRrmovq || icode == iJxx) begin
      case (ifun)
        4'h0:    Condition = 1'b1;
        4'h1:    Condition = (sfIn ^ ofIn) | zfIn;
        4'h2:    Condition = sfIn ^ ofIn;
        4'h3:    Condition = zfIn;
        4'h4:    Condition = ~zfIn;
        4'h5:    Condition = ~(sfIn ^ ofIn);
        4'h6:    Condition = ~(sfIn ^ ofIn) & ~zfIn;
        default: Condition = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccReg <= 3'b000;
    end else if (icode == iOpq && opValid) begin
      ccReg <= newFlags;
    end
  end

  assign CondititonCodes_Out = ccReg;

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - directed self-checking bench for the execute stage
module tb_execute;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [2:0]  ccIn;
  logic [63:0] valE;
  logic        Condition;
  logic [2:0]  ccOut;

  int checks = 0;
  int errors = 0;

  execute dut (
    .clk                 (clk),
    .rst                 (rst),
    .icode               (icode),
    .ifun                (ifun),
    .valA                (valA),
    .valB                (valB),
    .valC                (valC),
    .CondititonCodes_In  (ccIn),
    .valE                (valE),
    .Condition           (Condition),
    .CondititonCodes_Out (ccOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [2:0] cc);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; ccIn = cc;
    #1;
  endtask

  task automatic edgeStep();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] cmovExpect;

  initial begin
    rst = 1'b1;
    icode = 4'h0; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0; ccIn = 3'b000;
    #2;
    check("reset_cc", {61'd0, ccOut}, 64'd0);

    // OPq add held through a clock edge while reset is asserted must not load
    apply(4'h6, 4'h0, 64'd10211683239992122150, 64'd2545604381904918856, 64'd0, 3'b000);
    check("add_valE_in_reset", valE, 64'd12757287621897041006);
    edgeStep();
    check("cc_ignored_in_reset", {61'd0, ccOut}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    cmovExpect = 7'b1110001;
    for (int f = 0; f < 7; f++) begin
      apply(4'h2, f[3:0], 64'd15686049516996210692, 64'd0, 64'd0, 3'b000);
      check($sformatf("cmov_valE_%0d", f), valE, 64'd15686049516996210692);
      check($sformatf("cmov_cond_%0d", f), {63'd0, Condition}, {63'd0, cmovExpect[f]});
    end
    apply(4'h2, 4'h7, 64'd1, 64'd0, 64'd0, 3'b111);
    check("cmov_cond_ifun7", {63'd0, Condition}, 64'd0);

    apply(4'h3, 4'h0, 64'hx, 64'hx, 64'd4531598557225673514, 3'bxxx);
    check("irmovq_valE", valE, 64'd4531598557225673514);
    check("irmovq_cond", {63'd0, Condition}, 64'd0);

    apply(4'h4, 4'h0, 64'hx, 64'd8377612678370507997, 64'd2601896683644409162, 3'b000);
    check("rmmovq_valE", valE, 64'd10979509362014917159);

    @(negedge clk);
    apply(4'h6, 4'h0, 64'd10211683239992122150, 64'd2545604381904918856, 64'hx, 3'b000);
    check("add_valE", valE, 64'd12757287621897041006);
    edgeStep();
    check("add_cc", {61'd0, ccOut}, 64'b010);

    @(negedge clk);
    apply(4'h6, 4'h1, 64'd10211683239992122150, 64'd2545604381904918856, 64'd0, 3'b000);
    check("sub_valE", valE, 64'd10780665215622348322);
    edgeStep();
    check("sub_cc", {61'd0, ccOut}, 64'b011);

    @(negedge clk);
    apply(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 3'b000);
    check("and_valE", valE, 64'hF000);
    edgeStep();
    check("and_cc", {61'd0, ccOut}, 64'b000);

    @(negedge clk);
    apply(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 3'b000);
    check("xor_valE", valE, 64'd0);
    edgeStep();
    check("xor_cc", {61'd0, ccOut}, 64'b100);

    @(negedge clk);
    apply(4'h6, 4'h4, 64'd5, 64'd7, 64'd0, 3'b011);
    check("opq_ifun4_valE", valE, 64'd0);
    edgeStep();
    check("opq_ifun4_cc_hold", {61'd0, ccOut}, 64'b100);

    @(negedge clk);
    apply(4'h2, 4'h0, 64'd1, 64'd0, 64'd0, 3'b011);
    edgeStep();
    check("cmov_cc_hold", {61'd0, ccOut}, 64'b100);

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_cc", {61'd0, ccOut}, 64'd0);
    check("valE_during_reset", valE, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    apply(4'h6, 4'h0, 64'd10211683239992122150, 64'd2545604381904918856, 64'd0, 3'b000);
    edgeStep();
    check("cc_after_reset_release", {61'd0, ccOut}, 64'b010);

    @(negedge clk);
    apply(4'h8, 4'h0, 64'hx, 64'd8305201631521356197, 64'hx, 3'b000);
    check("call_valE", valE, 64'd8305201631521356189);
    apply(4'h9, 4'h0, 64'hx, 64'd2548618866013362580, 64'hx, 3'b000);
    check("ret_valE", valE, 64'd2548618866013362588);
    apply(4'hA, 4'h0, 64'd0, 64'd3219244442442772696, 64'hx, 3'b000);
    check("pushq_valE", valE, 64'd3219244442442772688);
    apply(4'hB, 4'h0, 64'd0, 64'd17278588888214152940, 64'hx, 3'b000);
    check("popq_valE", valE, 64'd17278588888214152948);
    apply(4'h7, 4'h3, 64'hx, 64'hx, 64'd1234, 3'b100);
    check("jxx_cond", {63'd0, Condition}, 64'd1);
    check("jxx_valE", valE, 64'd0);
    apply(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 3'b010);
    check("jxx_g_cond", {63'd0, Condition}, 64'd0);
    apply(4'h0, 4'h0, 64'd9, 64'd9, 64'd9, 3'b111);
    check("nop_valE", valE, 64'd0);
    check("nop_cond", {63'd0, Condition}, 64'd0);
    edgeStep();
    check("final_cc_hold", {61'd0, ccOut}, 64'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
